// File: rtl/saif_window_tracker_if.sv
// Report record channel from saif_window_tracker to the log collector.
// The master drives the record and its valid; the slave drives ready.
interface saif_window_tracker_if #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int counter_width_p   = 32,
  parameter int window_id_width_p = 8
) ();
  logic                         report_v_o;
  logic                         report_ready_i;
  logic [counter_width_p-1:0]   report_cycles_o;
  logic [counter_width_p-1:0]   report_instrs_o;
  logic [window_id_width_p-1:0] report_window_id_o;
  logic                         report_sat_o;
  logic [x_cord_width_p-1:0]    report_x_o;
  logic [y_cord_width_p-1:0]    report_y_o;

  modport master (
    output report_v_o, report_cycles_o, report_instrs_o, report_window_id_o,
           report_sat_o, report_x_o, report_y_o,
    input  report_ready_i
  );

  modport slave (
    input  report_v_o, report_cycles_o, report_instrs_o, report_window_id_o,
           report_sat_o, report_x_o, report_y_o,
    output report_ready_i
  );
endinterface

// File: rtl/saif_window_tracker.sv
// Measures SAIF capture windows (cycles, retired instructions, sequence id) and
// offers one report per window through a single-entry slot. Optional
// SAIF_WINDOW_DISPLAY_EN prints each loaded or dropped window.
//
// state  | meaning
// IDLE   | no capture window open; waiting for a rise of saif_en_i
// ACTIVE | window open; counting cycles and retired instructions
module saif_window_tracker #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int counter_width_p   = 32,
  parameter int window_id_width_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       saif_en_i,
  input  logic                       instr_retire_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  saif_window_tracker_if.master      report,
  output logic [counter_width_p-1:0] dropped_o
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [counter_width_p-1:0]   cnt_one = {{(counter_width_p-1){1'b0}}, 1'b1};
  localparam logic [window_id_width_p-1:0] id_one  = {{(window_id_width_p-1){1'b0}}, 1'b1};

  state_e                       state_r, state_n;
  logic                         en_r;
  logic                         rise, fall, count_en;
  logic                         accept, load, drop;
  logic [counter_width_p-1:0]   cycles_r, instrs_r;
  logic                         sat_r;
  logic [window_id_width_p-1:0] win_id_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      en_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      en_r    <= saif_en_i;
    end
  end

  always_comb begin
    state_n  = state_r;
    rise     = 1'b0;
    fall     = 1'b0;
    count_en = 1'b0;
    case (state_r)
      IDLE: begin
        if (saif_en_i && !en_r) begin
          rise    = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!saif_en_i) begin
          fall    = en_r;
          state_n = IDLE;
        end else begin
          count_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Live counters; the report slot keeps its own copy so a new window can
  // start while the previous record is still waiting for the collector.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycles_r <= '0;
      instrs_r <= '0;
      sat_r    <= 1'b0;
    end else if (rise) begin
      cycles_r <= cnt_one;
      instrs_r <= instr_retire_i ? cnt_one : '0;
      sat_r    <= 1'b0;
    end else if (count_en) begin
      if (cycles_r == '1) sat_r <= 1'b1;
      else                cycles_r <= cycles_r + cnt_one;
      if (instr_retire_i) begin
        if (instrs_r == '1) sat_r <= 1'b1;
        else                instrs_r <= instrs_r + cnt_one;
      end
    end
  end

  assign accept = report.report_v_o & report.report_ready_i;
  assign load   = fall & (~report.report_v_o | accept);
  assign drop   = fall & ~load;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      report.report_v_o         <= 1'b0;
      report.report_cycles_o    <= '0;
      report.report_instrs_o    <= '0;
      report.report_window_id_o <= '0;
      report.report_sat_o       <= 1'b0;
      report.report_x_o         <= '0;
      report.report_y_o         <= '0;
      win_id_r                  <= '0;
      dropped_o                 <= '0;
    end else begin
      if (load) begin
        report.report_v_o         <= 1'b1;
        report.report_cycles_o    <= cycles_r;
        report.report_instrs_o    <= instrs_r;
        report.report_window_id_o <= win_id_r;
        report.report_sat_o       <= sat_r;
        report.report_x_o         <= my_x_i;
        report.report_y_o         <= my_y_i;
      end else if (accept) begin
        report.report_v_o <= 1'b0;
      end
      if (fall) win_id_r <= win_id_r + id_one;
      if (drop && dropped_o != '1) dropped_o <= dropped_o + cnt_one;
    end
  end

`ifdef SAIF_WINDOW_DISPLAY_EN
  always @(posedge clk_i) begin
    if (!reset_i && load)
      $display("saif_window x=%0d y=%0d id=%0d cycles=%0d instrs=%0d sat=%0b",
               my_x_i, my_y_i, win_id_r, cycles_r, instrs_r, sat_r);
    if (!reset_i && drop)
      $display("saif_window WARNING dropped x=%0d y=%0d id=%0d",
               my_x_i, my_y_i, win_id_r);
  end
`else
  // Default build is silent; slot and handshake logic above are unchanged.
`endif

endmodule

// File: doc/saif_window_tracker.md
# saif_window_tracker

Per-tile testbench block sitting directly downstream of the vanilla core SAIF trigger generator. It consumes the generator's `saif_en` output and measures each power-capture window: active cycles, retired instructions, and window sequence number. At the end of each window it emits one report record to a log collector over a valid/ready handshake. It is not synthesized into the tile; it lives in the manycore testbench beside the trigger generator.

## Interface
Parameters:
- `x_cord_width_p`, "inv": width of tile X coordinate.
- `y_cord_width_p`, "inv": width of tile Y coordinate.
- `counter_width_p`, 32: width of cycle and instruction counters.
- `window_id_width_p`, 8: width of window sequence number; wraps.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `saif_en_i`  in  1  capture-window enable from trigger generator `saif_en_o`.
- `instr_retire_i`  in  1  one instruction retired this cycle.
- `my_x_i`  in  `x_cord_width_p`  tile X coordinate; copied into report.
- `my_y_i`  in  `y_cord_width_p`  tile Y coordinate; copied into report.
- `report_v_o`  out  1  report record valid.
- `report_ready_i`  in  1  collector accepts record.
- `report_cycles_o`  out  `counter_width_p`  active cycles in window.
- `report_instrs_o`  out  `counter_width_p`  retired instructions in window.
- `report_window_id_o`  out  `window_id_width_p`  window sequence number.
- `report_sat_o`  out  1  a counter saturated during window.
- `report_x_o` / `report_y_o`  out  coord widths  latched coordinates.
- `dropped_o`  out  `counter_width_p`  windows lost because report slot was busy.

## Operation
- States: IDLE, ACTIVE. Register `en_r` holds the previous `saif_en_i`.
- Rise (`saif_en_i`=1, `en_r`=0): IDLE->ACTIVE; cycle counter loads 1; instruction counter loads `instr_retire_i`; saturation flag cleared.
- ACTIVE and `saif_en_i`=1: cycle counter +1, instruction counter +`instr_retire_i`. Both saturate at all-ones; on saturation set sticky sat flag.
- Fall (`saif_en_i`=0, `en_r`=1): ACTIVE->IDLE; the completed window is offered to the report slot.
- Report slot: one entry. Loaded on fall if slot empty, or if slot full and `report_v_o & report_ready_i` the same cycle. Otherwise the window is discarded and `dropped_o` +1 (saturating).
- Window id: counter incremented on every fall (loaded or dropped); loaded value is the id before increment; first window id = 0; wraps modulo 2^`window_id_width_p`.
- Slot clears on `report_v_o & report_ready_i` when no simultaneous load.
- Rise in the cycle immediately after a fall is legal: new window starts while prior report is pending; report data is held separately from live counters.
- `saif_en_i` high during reset: after reset release, first cycle with `saif_en_i`=1 is treated as a rise (since `en_r` reset to 0).

## Timing
- Reset values: `report_v_o`=0, all report data 0, `dropped_o`=0, `en_r`=0, state IDLE, counters 0, window id 0.
- Reset mid-window discards the window without report or drop count.
- Fall seen at cycle t -> `report_v_o`=1 at t+1 (one-cycle latency).
- Report outputs stable while `report_v_o`=1 and `report_ready_i`=0.
- Window of N high cycles of `saif_en_i` reports `report_cycles_o`=N.
- Back-to-back handshake: accept and new load in same cycle keeps `report_v_o`=1 with new data next cycle.

## Configuration
- `SAIF_WINDOW_DISPLAY_EN`: when defined, each report load prints one `$display` line with x, y, window id, cycles, instructions, sat; each drop prints a warning line with x, y, window id. When undefined, no display statements are compiled; handshake behaviour identical.

## Test plan
- After reset, `saif_en_i` high 10 cycles with `instr_retire_i` high on 4 of them, ready=1 -> one record: cycles=10, instrs=4, id=0, sat=0, `report_v_o` one cycle after fall.
- Two windows (5 then 3 cycles), ready=0 throughout -> first record (cycles=5, id=0) held stable, second dropped, `dropped_o`=1; raise ready -> record accepted, `report_v_o`=0 next cycle.
- Fall followed by rise next cycle, ready=1 -> records id=0 and id=1, both cycle counts exact.
- `counter_width_p`=4, window 20 cycles all retiring -> cycles=15, instrs=15, sat=1.
- Assert reset at cycle 3 of a 10-cycle window -> no record, `dropped_o`=0; next window reports id=0.
- `window_id_width_p`=2, five 1-cycle windows with ready=1 -> ids 0,1,2,3,0.
